seg_scan_mux: RTL

Time-multiplexed seven-segment display scanner for the board's common-anode displays, parametrised in digit count and inter-frame blank slots. It takes a packed vector of hex/BCD digit codes plus per-digit decimal-point and blank masks, snapshots them once per frame, and drives one digit per scan tick. It sits between the game timer/score logic and the display pins, and replaces per-screen hand-written scanners.

---
 rtl/seg_scan_pkg.sv | 20 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg_scan_mux.sv | 116 +++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scanner: dark pattern, hex glyph table
// and the slot-counter width helper.
package seg_scan_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} glyphs for codes 0..F
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // A single-slot frame still needs a one-bit counter
   function automatic int slot_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit code to active-low seven-segment glyph.
module seg7_hex_decode
   import seg_scan_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   assign seg = GLYPH_TABLE[code];

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode seven-segment scanner with per-frame input snapshot.
// Optional LEADING_ZERO_BLANK_EN: darken leading zero digits of each frame.
module seg_scan_mux
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int BLANK_SLOTS = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tick,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    dp,
   output logic                    frame_start
);

   localparam int NSLOTS = NUM_DIGITS + BLANK_SLOTS;
   localparam int SW     = slot_w(NSLOTS);
   localparam logic [SW-1:0] LAST = SW'(NSLOTS - 1);

   logic [SW-1:0]           slot_p0;
   logic [SW-1:0]           slot_nxt;
   logic                    wrap;
   logic [4*NUM_DIGITS-1:0] dig_sh_p0;
   logic [NUM_DIGITS-1:0]   dp_sh_p0;
   logic [NUM_DIGITS-1:0]   blk_sh_p0;
   logic [4*NUM_DIGITS-1:0] src_dig;
   logic [NUM_DIGITS-1:0]   src_dp;
   logic [NUM_DIGITS-1:0]   src_blk;
   logic [NUM_DIGITS-1:0]   lz;
   logic [3:0]              sel_code;
   logic [6:0]              sel_glyph;
   logic                    dark;
   logic [NUM_DIGITS-1:0]   an_nxt;
   logic                    dp_nxt;
   logic [6:0]              seg_nxt;

   assign wrap     = (slot_p0 == LAST);
   assign slot_nxt = wrap ? '0 : slot_p0 + 1'b1;

   // Slot 0 is built from the live inputs that are being snapshotted on this edge
   assign src_dig = wrap ? digits     : dig_sh_p0;
   assign src_dp  = wrap ? dp_mask    : dp_sh_p0;
   assign src_blk = wrap ? blank_mask : blk_sh_p0;

`ifdef LEADING_ZERO_BLANK_EN
   logic lz_run;

   always_comb begin
      lz     = '0;
      lz_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (lz_run && (src_dig[4*i +: 4] == 4'd0) && !src_dp[i])
            lz[i] = 1'b1;
         else
            lz_run = 1'b0;
      end
   end
`else
   assign lz = '0;
`endif

   always_comb begin
      an_nxt   = '1;
      sel_code = '0;
      dark     = 1'b1;
      dp_nxt   = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (slot_nxt == SW'(NUM_DIGITS - 1 - i)) begin
            an_nxt[i] = 1'b0;
            sel_code  = src_dig[4*i +: 4];
            dark      = src_blk[i] | lz[i];
            dp_nxt    = src_blk[i] | lz[i] | ~src_dp[i];
         end
      end
   end

   seg7_hex_decode u_dec (
      .code (sel_code),
      .seg  (sel_glyph)
   );

   assign seg_nxt = dark ? SEG_OFF : sel_glyph;

   // ---- output / state register stage ----
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_p0     <= LAST;
         seg         <= SEG_OFF;
         an          <= '1;
         dp          <= 1'b1;
         frame_start <= 1'b0;
         dig_sh_p0   <= '0;
         dp_sh_p0    <= '0;
         blk_sh_p0   <= '0;
      end else begin
         frame_start <= tick & wrap;
         if (tick) begin
            slot_p0 <= slot_nxt;
            seg     <= seg_nxt;
            an      <= an_nxt;
            dp      <= dp_nxt;
            if (wrap) begin
               dig_sh_p0 <= digits;
               dp_sh_p0  <= dp_mask;
               blk_sh_p0 <= blank_mask;
            end
         end
      end
   end

endmodule
